led_pwm_driver: RTL

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

---
 rtl/led_pwm_driver_if.sv | 31 +++
 rtl/led_pwm_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_driver_if.sv
// Bundle between the LED PWM driver and its host: control inputs, the pin-level
// outputs and a read-only view of the animation state machines.
interface led_pwm_driver_if;
    // wr_en is a one-cycle strobe with no back-pressure: wr_idx/wr_duty are taken
    // on the edge where wr_en=1, and there is no ready, so the host may strobe
    // every cycle.
    logic [1:0] mode;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_duty;
    logic       period_start;
    logic [5:0] led_n;

    logic [1:0] dbg_mode_q;
    logic [7:0] dbg_level;
    logic       dbg_breathe_down;
    logic [2:0] dbg_pos;
    logic       dbg_chase_down;

    modport master (
        output mode, wr_en, wr_idx, wr_duty,
        input  period_start, led_n,
        input  dbg_mode_q, dbg_level, dbg_breathe_down, dbg_pos, dbg_chase_down
    );

    modport slave (
        input  mode, wr_en, wr_idx, wr_duty,
        output period_start, led_n,
        output dbg_mode_q, dbg_level, dbg_breathe_down, dbg_pos, dbg_chase_down
    );
endinterface

// File: rtl/led_pwm_driver.sv
// Six-channel 8-bit PWM LED driver with double-buffered duties and static,
// breathe, chase and off modes; all mode/duty changes land on a period boundary.
module led_pwm_driver #(
    parameter int CLK_FREQ_HZ = 27_000_000,
    parameter int STEP_DIV    = CLK_FREQ_HZ / 512
) (
    input  logic            clk,
    input  logic            sys_rst,
    led_pwm_driver_if.slave bus
);

    localparam int NUM_LEDS = 6;
    localparam int STEP_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'b00,
        MODE_BREATHE = 2'b01,
        MODE_CHASE   = 2'b10,
        MODE_OFF     = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [7:0]        pwm_cnt;
    logic              pwm_wrap;
    logic [STEP_W-1:0] step_cnt;
    logic              step_tick;
    mode_e             mode_q;

    logic [7:0] shadow [NUM_LEDS];
    logic [7:0] active [NUM_LEDS];
    logic       wr_hit;

    dir_e       breathe_dir, breathe_dir_nxt;
    logic [7:0] level, level_nxt;
    dir_e       chase_dir, chase_dir_nxt;
    logic [2:0] pos, pos_nxt;

    logic [NUM_LEDS-1:0][7:0] eff_duty;
    logic [NUM_LEDS-1:0]      led_on;
    logic [NUM_LEDS-1:0]      led_n_q;
    logic                     period_start_q;

    assign pwm_wrap  = (pwm_cnt == 8'hFF);
    assign step_tick = (step_cnt == STEP_LAST);
    assign wr_hit    = bus.wr_en && (bus.wr_idx < 3'd6);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            pwm_cnt  <= 8'd0;
            step_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (step_tick) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // Active duties and mode only move at the 255->0 wrap; a write on that same
    // edge goes to shadow and waits for the following wrap.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                shadow[i] <= 8'd0;
                active[i] <= 8'd0;
            end
            mode_q <= MODE_OFF;
        end else begin
            if (pwm_wrap) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    active[i] <= shadow[i];
                end
                mode_q <= mode_e'(bus.mode);
            end
            if (wr_hit) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (bus.wr_idx == 3'(i)) begin
                        shadow[i] <= bus.wr_duty;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            breathe_dir <= DIR_UP;
            level       <= 8'd0;
        end else begin
            breathe_dir <= breathe_dir_nxt;
            level       <= level_nxt;
        end
    end

    // The level sits at each extreme for one tick while the direction turns.
    always_comb begin
        breathe_dir_nxt = breathe_dir;
        level_nxt       = level;
        if (step_tick) begin
            case (breathe_dir)
                DIR_UP: begin
                    if (level == 8'hFF) begin
                        breathe_dir_nxt = DIR_DOWN;
                    end else begin
                        level_nxt = level + 8'd1;
                    end
                end
                DIR_DOWN: begin
                    if (level == 8'd0) begin
                        breathe_dir_nxt = DIR_UP;
                    end else begin
                        level_nxt = level - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            chase_dir <= DIR_UP;
            pos       <= 3'd0;
        end else begin
            chase_dir <= chase_dir_nxt;
            pos       <= pos_nxt;
        end
    end

    // Chase bounces off the ends in the same tick, so LEDs 0 and 5 never dwell.
    always_comb begin
        chase_dir_nxt = chase_dir;
        pos_nxt       = pos;
        if (step_tick) begin
            case (chase_dir)
                DIR_UP: begin
                    if (pos == 3'd5) begin
                        chase_dir_nxt = DIR_DOWN;
                        pos_nxt       = 3'd4;
                    end else begin
                        pos_nxt = pos + 3'd1;
                    end
                end
                DIR_DOWN: begin
                    if (pos == 3'd0) begin
                        chase_dir_nxt = DIR_UP;
                        pos_nxt       = 3'd1;
                    end else begin
                        pos_nxt = pos - 3'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            eff_duty[i] = 8'd0;
            case (mode_q)
                MODE_STATIC:  eff_duty[i] = active[i];
                MODE_BREATHE: eff_duty[i] = level;
                MODE_CHASE:   eff_duty[i] = (pos == 3'(i)) ? 8'hFF : 8'h00;
                default:      eff_duty[i] = 8'd0;
            endcase
            led_on[i] = (pwm_cnt < eff_duty[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            led_n_q        <= '1;
            period_start_q <= 1'b0;
        end else begin
            led_n_q        <= ~led_on;
            period_start_q <= (pwm_cnt == 8'd0);
        end
    end

    assign bus.led_n            = led_n_q;
    assign bus.period_start     = period_start_q;
    assign bus.dbg_mode_q       = mode_q;
    assign bus.dbg_level        = level;
    assign bus.dbg_breathe_down = (breathe_dir == DIR_DOWN);
    assign bus.dbg_pos          = pos;
    assign bus.dbg_chase_down   = (chase_dir == DIR_DOWN);

endmodule
